// File: rtl/my_types_pkg.sv
// Shared types for the pipeline skid register.
// State encoding, max occupancy and a state-to-count helper.
package my_types_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    localparam int unsigned PIPE_MAX_OCC = 2;

    function automatic logic [1:0] pipe_occ(input pipe_state_t s);
        logic [1:0] n;
        n = 2'd0;
        unique case (s)
            PS_EMPTY: n = 2'd0;
            PS_ONE:   n = 2'd1;
            PS_TWO:   n = 2'(PIPE_MAX_OCC);
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter with synchronous clear.
// Adds 0..2 per cycle and sticks at all-ones.
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W+1:0] MAX = {2'b00, {CNT_W{1'b1}}};

    logic [CNT_W+1:0] sum;

    // Widened sum so overflow is visible before clamping.
    always_comb begin
        sum = {2'b00, count} + {{CNT_W{1'b0}}, inc};
    end

    // Reset and clear beat counting; clamp at the maximum.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (sum > MAX) begin
            count <= '1;
        end else begin
            count <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with optional skid entry.
// Flush drops all entries; stall and drop counters saturate.
module pipe_skid_reg
    import my_types_pkg::*;
#(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter bit              SKID_EN   = 1'b1,
    parameter int              CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [1:0]       occ_q;
    logic             accept, deliver;
    logic [1:0]       stall_inc, drop_inc;

    // Handshake: skid mode never looks at out_ready for in_ready.
    always_comb begin
        out_valid = (state_q != PS_EMPTY) & ~flush;
        if (SKID_EN) begin
            in_ready = (state_q != PS_TWO) & ~flush;
        end else begin
            in_ready = ((state_q == PS_EMPTY) | out_ready) & ~flush;
        end
        accept  = in_valid & in_ready;
        deliver = out_valid & out_ready;
    end

    // Next state and payload moves; flush empties everything.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = PS_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            unique case (state_q)
                PS_EMPTY: begin
                    if (accept) begin
                        state_d = PS_ONE;
                        main_d  = in_data;
                    end
                end
                PS_ONE: begin
                    if (accept && deliver) begin
                        main_d = in_data;
                    end else if (accept && SKID_EN) begin
                        state_d = PS_TWO;
                        skid_d  = in_data;
                    end else if (deliver) begin
                        state_d = PS_EMPTY;
                        main_d  = NOP_VALUE;
                    end
                end
                PS_TWO: begin
                    if (deliver) begin
                        state_d = PS_ONE;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = PS_EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    // State, payload and occupancy registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= PS_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
            occ_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            occ_q   <= pipe_occ(state_d);
        end
    end

    // Counter increments: one per stalled cycle, held count on flush.
    always_comb begin
        stall_inc = {1'b0, out_valid & ~out_ready};
        drop_inc  = flush ? occ_q : 2'd0;
    end

    assign out_data  = main_q;
    assign occupancy = occ_q;

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall (
        .CLK   (CLK),
        .nRST  (nRST),
        .clr   (cnt_clr),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_drop (
        .CLK   (CLK),
        .nRST  (nRST),
        .clr   (cnt_clr),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
- REQ-001: The block SHALL have one clock; reset is synchronous and active-low.
- REQ-002: Parameter WIDTH, 32, payload width in bits; legal range 1..1024.
- REQ-003: Parameter NOP_VALUE, '0 (WIDTH bits), bubble payload loaded on reset, flush and drain.
- REQ-004: Parameter SKID_EN, 1; 1 = two-entry skid mode, 0 = single-entry mode.
- REQ-005: Parameter CNT_W, 16, width of both performance counters.
- REQ-006: CLK  in  1  clock; all state changes on its rising edge.
- REQ-007: nRST  in  1  synchronous active-low reset.
- REQ-008: in_valid  in  1  upstream offers in_data.
- REQ-009: in_ready  out  1  block can accept this cycle.
- REQ-010: in_data  in  WIDTH  upstream payload.
- REQ-011: out_valid  out  1  out_data is valid.
- REQ-012: out_ready  in  1  downstream takes out_data this cycle.
- REQ-013: out_data  out  WIDTH  head entry payload.
- REQ-014: flush  in  1  discard all entries; takes priority over every transfer.
- REQ-015: cnt_clr  in  1  zero both counters.
- REQ-016: occupancy  out  2  number of held entries, 0..2.
- REQ-017: stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
- REQ-018: drop_cnt  out  CNT_W  saturating count of entries discarded by flush.

Function
- REQ-019: Accept = in_valid & in_ready; deliver = out_valid & out_ready; nothing transfers without the matching handshake.
- REQ-020: The FSM SHALL use the states EMPTY, ONE and TWO; TWO is unreachable when SKID_EN=0.
- REQ-021: Outputs: out_valid = (state != EMPTY) & ~flush; out_data = main register.
- REQ-022: in_ready with SKID_EN=1: (state != TWO) & ~flush, with no combinational path from out_ready.
- REQ-023: in_ready with SKID_EN=0: ((state == EMPTY) | out_ready) & ~flush.
- REQ-024: EMPTY: accept -> ONE, main <= in_data.
- REQ-025: ONE: accept & deliver -> ONE, main <= in_data; accept only -> TWO, skid <= in_data; deliver only -> EMPTY, main <= NOP_VALUE; neither -> hold.
- REQ-026: TWO: deliver -> ONE, main <= skid, skid <= NOP_VALUE; else hold.
- REQ-027: Ordering SHALL be strict FIFO; payloads pass bit-exact, with one cycle latency from accept to out_valid when EMPTY.
- REQ-028: Flush cycle: next state EMPTY and main, skid <= NOP_VALUE.
- REQ-029: In a flush cycle no accept or deliver occurs and in_data is discarded.
- REQ-030: In a flush cycle drop_cnt += occupancy (0, 1 or 2), saturating.
- REQ-031: Priority SHALL be nRST > flush > cnt_clr > counting.
- REQ-032: cnt_clr with flush SHALL zero the counters, and that flush's drops are not counted.
- REQ-033: Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
- REQ-034: occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO and is registered.

Reset
- REQ-035: When nRST=0 at a clock edge: state EMPTY, main and skid = NOP_VALUE, both counters 0, occupancy 0.
- REQ-036: During and after reset out_valid=0 and out_data=NOP_VALUE.
- REQ-037: in_ready SHALL be 1 in the first cycle after reset release.
- REQ-038: Reset mid-transfer SHALL discard all entries without incrementing drop_cnt.

Structure
- REQ-039: Typedef pipe_state_t {PS_EMPTY, PS_ONE, PS_TWO} SHALL live in my_types_pkg.
- REQ-040: Constant PIPE_MAX_OCC = 2 SHALL live in my_types_pkg.
- REQ-041: Sub-module pipe_sat_cnt (parameter CNT_W; inputs clr, inc[1:0]; output count) SHALL be instantiated twice.
- REQ-042: Register and FSM updates SHALL be in one clocked process; ready/valid in combinational logic.

Verification
- REQ-043: Reset then in_valid=1, in_data=0xA5A5A5A5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5A5A5A5, occupancy=1.
- REQ-044: SKID_EN=1, out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0, stall_cnt increments per cycle; raise out_ready -> 0x11 then 0x22 delivered, in order.
- REQ-045: Occupancy 2 plus flush=1 with in_valid=1, in_data=0x33 -> next cycle occupancy=0, out_data=NOP_VALUE, drop_cnt=2, and 0x33 never delivered.
- REQ-046: SKID_EN=0, out_ready=1, stream 0x1..0x8 back-to-back -> one transfer per cycle, in_ready=1 throughout, occupancy never 2.
- REQ-047: CNT_W=2, hold out_ready=0 for 6 cycles with occupancy 1 -> stall_cnt=3 (saturated); cnt_clr=1 -> stall_cnt=0 next cycle.
- REQ-048: nRST=0 asserted at occupancy 2 -> next edge occupancy=0, drop_cnt=0, out_valid=0, in_ready=1 after release.
